hazard_fwd_unit: RTL and testbench

//   Hazard and forwarding control for the 5-stage pipeline. Tracks rd/regwrite/memread of

---
 rtl/hazard_fwd_unit.sv | 132 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Tracks ID/EX, EX/MEM and MEM/WB destination info and drives the EX bypass selects, stall and flush.
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_id_i,
    input  logic [REG_ADDR_W-1:0] rs1_id_i,
    input  logic [REG_ADDR_W-1:0] rs2_id_i,
    input  logic [REG_ADDR_W-1:0] rd_id_i,
    input  logic                  regwrite_id_i,
    input  logic                  memread_id_i,
    input  logic                  pc_src_ex_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    logic                  r_idex_valid;
    logic [REG_ADDR_W-1:0] r_idex_rs1;
    logic [REG_ADDR_W-1:0] r_idex_rs2;
    logic [REG_ADDR_W-1:0] r_idex_rd;
    logic                  r_idex_regwrite;
    logic                  r_idex_memread;

    logic [REG_ADDR_W-1:0] r_exmem_rd;
    logic                  r_exmem_regwrite;
    logic                  r_exmem_memread;

    logic [REG_ADDR_W-1:0] r_memwb_rd;
    logic                  r_memwb_regwrite;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic                  w_exmem_fwd_ok;
    logic                  w_memwb_fwd_ok;
    logic                  w_load_use;
    logic                  w_flush;
    logic                  w_stall;
    logic                  w_bubble;

    assign w_exmem_fwd_ok = r_exmem_regwrite && (r_exmem_rd != '0);
    assign w_memwb_fwd_ok = r_memwb_regwrite && (r_memwb_rd != '0);

    always_comb begin
        fwd_a_o = SEL_RF;
        fwd_b_o = SEL_RF;
        if (r_idex_valid) begin
            if (w_exmem_fwd_ok && (r_exmem_rd == r_idex_rs1))
                fwd_a_o = SEL_EXMEM;
            else if (w_memwb_fwd_ok && (r_memwb_rd == r_idex_rs1))
                fwd_a_o = SEL_MEMWB;

            if (w_exmem_fwd_ok && (r_exmem_rd == r_idex_rs2))
                fwd_b_o = SEL_EXMEM;
            else if (w_memwb_fwd_ok && (r_memwb_rd == r_idex_rs2))
                fwd_b_o = SEL_MEMWB;
        end
    end

    // Flush is gated by reset so every output is quiet while reset is held.
    assign w_flush    = pc_src_ex_i && rst_n_i;
    assign w_load_use = r_idex_valid && r_idex_memread && (r_idex_rd != '0) && valid_id_i &&
                        ((r_idex_rd == rs1_id_i) || (r_idex_rd == rs2_id_i));
    assign w_stall    = w_load_use && !pc_src_ex_i;
    assign w_bubble   = w_flush || w_stall;

    assign stall_o     = w_stall;
    assign flush_o     = w_flush;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idex_valid     <= 1'b0;
            r_idex_rs1       <= '0;
            r_idex_rs2       <= '0;
            r_idex_rd        <= '0;
            r_idex_regwrite  <= 1'b0;
            r_idex_memread   <= 1'b0;
            r_exmem_rd       <= '0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_memread  <= 1'b0;
            r_memwb_rd       <= '0;
            r_memwb_regwrite <= 1'b0;
        end else begin
            r_memwb_rd       <= r_exmem_rd;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_exmem_rd       <= r_idex_rd;
            r_exmem_regwrite <= r_idex_regwrite && r_idex_valid;
            r_exmem_memread  <= r_idex_memread && r_idex_valid;
            if (w_bubble) begin
                r_idex_valid    <= 1'b0;
                r_idex_rs1      <= '0;
                r_idex_rs2      <= '0;
                r_idex_rd       <= '0;
                r_idex_regwrite <= 1'b0;
                r_idex_memread  <= 1'b0;
            end else begin
                r_idex_valid    <= valid_id_i;
                r_idex_rs1      <= rs1_id_i;
                r_idex_rs2      <= rs2_id_i;
                r_idex_rd       <= rd_id_i;
                r_idex_regwrite <= regwrite_id_i;
                r_idex_memread  <= memread_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding priority, load-use stall, flush, x0 and reset.
// A second instance with 2-bit counters exercises counter saturation.
module tb_hazard_fwd_unit;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       valid_id_i;
    logic [4:0] rs1_id_i;
    logic [4:0] rs2_id_i;
    logic [4:0] rd_id_i;
    logic       regwrite_id_i;
    logic       memread_id_i;
    logic       pc_src_ex_i;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       stall_o;
    logic       flush_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    logic [1:0] sat_fwd_a;
    logic [1:0] sat_fwd_b;
    logic       sat_stall;
    logic       sat_flush;
    logic [1:0] sat_stall_cnt;
    logic [1:0] sat_flush_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_id_i(valid_id_i),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i), .rd_id_i(rd_id_i),
        .regwrite_id_i(regwrite_id_i), .memread_id_i(memread_id_i),
        .pc_src_ex_i(pc_src_ex_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_o(stall_o), .flush_o(flush_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_id_i(valid_id_i),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i), .rd_id_i(rd_id_i),
        .regwrite_id_i(regwrite_id_i), .memread_id_i(memread_id_i),
        .pc_src_ex_i(pc_src_ex_i), .fwd_a_o(sat_fwd_a), .fwd_b_o(sat_fwd_b),
        .stall_o(sat_stall), .flush_o(sat_flush),
        .stall_cnt_o(sat_stall_cnt), .flush_cnt_o(sat_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        valid_id_i    = v;
        rs1_id_i      = rs1;
        rs2_id_i      = rs2;
        rd_id_i       = rd;
        regwrite_id_i = rw;
        memread_id_i  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i     = 1'b0;
        pc_src_ex_i = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_flush_cnt", flush_cnt_o, 32'd0);
        pc_src_ex_i = 1'b0;
        #1;
        rst_n_i = 1'b1;
        tick();

        // 1: back-to-back dependency -> EX/MEM forward on A
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        chk("t1_stall", 32'(stall_o), 32'd0);
        tick();
        chk("t1_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("t1_fwd_b", 32'(fwd_b_o), 32'd0);

        // 2: one instruction between producer and consumer -> MEM/WB forward on B
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd7, 5'd10, 1'b1, 1'b0);
        tick();
        chk("t2_fwd_b", 32'(fwd_b_o), 32'd1);
        chk("t2_fwd_a", 32'(fwd_a_o), 32'd0);

        // 3: two writers of x3 -> newest (EX/MEM) wins
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
        tick();
        chk("t3_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("t3_fwd_b", 32'(fwd_b_o), 32'd0);

        // 4: load-use -> one stall, bubble, then MEM/WB forward
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 5'd11, 5'd12, 1'b1, 1'b0);
        chk("t4_stall", 32'(stall_o), 32'd1);
        chk("t4_cnt_before", stall_cnt_o, 32'd0);
        tick();
        chk("t4_cnt_after", stall_cnt_o, 32'd1);
        chk("t4_stall_once", 32'(stall_o), 32'd0);
        chk("t4_bubble_fwd_a", 32'(fwd_a_o), 32'd0);
        tick();
        chk("t4_fwd_a", 32'(fwd_a_o), 32'd1);
        chk("t4_cnt_hold", stall_cnt_o, 32'd1);

        // 5: load-use with taken branch in the same cycle -> flush wins
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 5'd0, 5'd13, 1'b1, 1'b0);
        pc_src_ex_i = 1'b1;
        #1;
        chk("t5_flush", 32'(flush_o), 32'd1);
        chk("t5_stall", 32'(stall_o), 32'd0);
        tick();
        pc_src_ex_i = 1'b0;
        #1;
        chk("t5_flush_cnt", flush_cnt_o, 32'd1);
        chk("t5_stall_cnt", stall_cnt_o, 32'd1);
        chk("t5_no_stall_bubble", 32'(stall_o), 32'd0);
        chk("t5_bubble_fwd_a", 32'(fwd_a_o), 32'd0);
        tick();

        // 6: x0 destinations never forward and never stall
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0);
        chk("t6_x0_stall", 32'(stall_o), 32'd0);
        tick();
        chk("t6_x0_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("t6_x0_fwd_b", 32'(fwd_b_o), 32'd0);

        // 6b: reset mid-stream clears state asynchronously
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd15, 1'b1, 1'b0);
        chk("t6_pre_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("t6_pre_stall", 32'(stall_o), 32'd1);
        #2;
        rst_n_i     = 1'b0;
        pc_src_ex_i = 1'b1;
        #1;
        chk("t6_rst_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("t6_rst_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("t6_rst_stall", 32'(stall_o), 32'd0);
        chk("t6_rst_flush", 32'(flush_o), 32'd0);
        chk("t6_rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("t6_rst_flush_cnt", flush_cnt_o, 32'd0);
        tick();
        pc_src_ex_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n_i = 1'b1;
        tick();
        chk("t6_post_fwd_a", 32'(fwd_a_o), 32'd0);

        // counter saturation: five flush cycles
        pc_src_ex_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pc_src_ex_i = 1'b0;
        #1;
        chk("sat_main_flush_cnt", flush_cnt_o, 32'd5);
        chk("sat_small_flush_cnt", 32'(sat_flush_cnt), 32'd3);
        chk("sat_small_stall_cnt", 32'(sat_stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
